r2n_buffer_o: RTL
=================

Name: r2n_buffer_o

Overview:
- Ready-to-Normal buffer for the OUTPUT matrix. It is the inverse of the input-side normal-to-ready slicer.
- Accepts blocked MAC results: one beat holds NUM_CORES vertically stacked BLOCK_SIZE x BLOCK_SIZE blocks.
- Reassembles the blocks into full row-major rows of COL elements and emits one row per handshake.
- Sits between the Multi-MAC core array and the downstream row consumer. A ping-pong band store lets filling and draining overlap.

Parameters:
- WIDTH, 16, element width in bits (fixed-point; the block does no arithmetic on data).
- FRAC_WIDTH, 8, fractional bits; carried for consistency, unused internally.
- BLOCK_SIZE, 2, block edge length.
- ROW, 64, output matrix rows; must be a multiple of BLOCK_SIZE*NUM_CORES.
- COL, 64, output matrix columns; must be a multiple of BLOCK_SIZE.
- NUM_CORES, 4, MAC cores, i.e. blocks per input beat.
- Derived localparams:
  - CHUNK_SIZE = BLOCK_SIZE^2
  - BAND_ROWS = BLOCK_SIZE*NUM_CORES
  - BLOCKS_PER_ROW = COL/BLOCK_SIZE
  - NUM_BANDS = ROW/BAND_ROWS
  - IN_W = WIDTH*CHUNK_SIZE*NUM_CORES

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start/enable; input acceptance occurs only while high
- in_valid  in  1  beat valid from cores
- in_ready  out  1  buffer can accept a beat
- in_data  in  IN_W  NUM_CORES blocks, core 0 in the MSBs
- out_valid  out  1  a full row is available
- out_ready  in  1  downstream accepts the row
- out_data  out  WIDTH*COL  row-major row, column 0 in the MSBs
- out_row_idx  out  clog2(ROW)  matrix row index of out_data
- band_done  out  1  one-cycle pulse when a band's last row is handshaken
- buffer_done  out  1  one-cycle pulse after the final row of the matrix

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. Reset clears the following; storage contents are not reset (don't care):
  - state = IDLE
  - in_ready = 0, out_valid = 0, band_done = 0, buffer_done = 0, out_row_idx = 0
  - bank full flags = 00
  - wr_bank = rd_bank = 0
  - all counters = 0
- FSM:
  - IDLE: in_ready = 0. Go to RUN when en = 1.
  - RUN: active. Go to DONE on the out handshake of row ROW-1.
  - DONE: buffer_done = 1 for exactly one cycle, then return to IDLE. Counters are already cleared, so a new matrix can follow.
- Input mapping, for a beat at block column c (0..BLOCKS_PER_ROW-1):
  - Core k's block is in_data[IN_W-1-k*CHUNK_SIZE*WIDTH -: CHUNK_SIZE*WIDTH].
  - Block element e = r*BLOCK_SIZE+cc sits at [block_msb - e*WIDTH -: WIDTH].
  - It is written to band row k*BLOCK_SIZE+r, column c*BLOCK_SIZE+cc of bank wr_bank.
- Input ordering:
  - Beats arrive column-first within a band, then band by band.
  - in_ready = (state==RUN) && en && !full[wr_bank] && (wr_band < NUM_BANDS).
  - A beat is accepted when in_valid && in_ready. The write lands on the next clock edge.
- End of a band's input: when the beat with c == BLOCKS_PER_ROW-1 is accepted:
  - set full[wr_bank];
  - toggle wr_bank;
  - clear c;
  - increment wr_band.
- Output:
  - out_valid = (state==RUN) && full[rd_bank].
  - out_data is combinational from bank rd_bank, row rd_row; element j is at [WIDTH*COL-1-j*WIDTH -: WIDTH].
  - out_data and out_row_idx are stable while out_valid && !out_ready.
  - out_row_idx = rd_band*BAND_ROWS + rd_row.
- On each out handshake, increment rd_row. At rd_row == BAND_ROWS-1:
  - clear full[rd_bank];
  - toggle rd_bank;
  - reset rd_row to 0;
  - increment rd_band;
  - pulse band_done.
- Latency: out_valid rises on the cycle after the clock edge that accepts the band's last beat.
- Simultaneous events:
  - Setting one bank's full flag while clearing the other bank's flag in the same cycle must both take effect.
  - Writing to a full bank is impossible by construction.
- With both banks full, in_ready = 0 until a bank drains. A newly freed bank allows in_ready = 1 on the next cycle.
- If en drops mid-RUN, input stalls (in_ready = 0) but output continues draining. Band counters are preserved.
- rst_n asserted mid-operation: all flags and counters are cleared immediately; partial data is discarded.
- out_ready held low indefinitely: no data loss; at most two bands are buffered.

Test Plan:
- Test configuration: ROW=16, COL=8, NUM_CORES=2, BLOCK_SIZE=2, so BAND_ROWS=4, BLOCKS_PER_ROW=4, NUM_BANDS=4. Element value = row*COL+col.
- Ordering: feed matrix value row*COL+col as 16 blocked beats, out_ready=1 -> 16 rows in order.
  - Row 5 reads 40..47 MSB-first; out_row_idx = 0..15.
  - band_done pulses 4 times; buffer_done pulses once, one cycle after row 15.
- Latency: first band's 4th beat accepted at edge t -> out_valid=1 in the cycle after t, with out_row_idx=0.
- Backpressure: out_ready=0 throughout, in_valid=1 -> in_ready drops after 8 accepted beats (both banks full).
  - Raise out_ready -> rows 0..3 drain, then in_ready=1 again with no corruption.
- Overlap: out_ready toggling 1/0 with continuous in_valid -> writing band 2 concurrent with reading band 1; output matrix bit-exact.
- Stall on en: drop en after 3 beats for 10 cycles -> in_ready=0, no writes.
  - Resume -> row 0..3 data correct.
- Reset mid-run: assert rst_n=0 during band 1 -> out_valid=0, in_ready=0 immediately.
  - Restart a full matrix -> correct output from row 0.

Source files
------------

// File: rtl/r2n_buffer_o.sv
// rtl/r2n_buffer_o.sv - ready-to-normal output buffer: blocked MAC beats in, row-major rows out
// Ping-pong band store; one bank fills from the cores while the other drains rows downstream.
module r2n_buffer_o #(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int BLOCK_SIZE = 2,
  parameter int ROW        = 64,
  parameter int COL        = 64,
  parameter int NUM_CORES  = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  en,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE*NUM_CORES-1:0]      in_data,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [WIDTH*COL-1:0]                                  out_data,
  output logic [$clog2(ROW)-1:0]                                out_row_idx,
  output logic                                                  band_done,
  output logic                                                  buffer_done
);

  localparam int CHUNK_SIZE     = BLOCK_SIZE * BLOCK_SIZE;
  localparam int BAND_ROWS      = BLOCK_SIZE * NUM_CORES;
  localparam int BLOCKS_PER_ROW = COL / BLOCK_SIZE;
  localparam int NUM_BANDS      = ROW / BAND_ROWS;
  localparam int IN_W           = WIDTH * CHUNK_SIZE * NUM_CORES;
  localparam int SLICE_W        = WIDTH * BLOCK_SIZE;
  localparam int RW             = $clog2(ROW);
  localparam int CW             = (BLOCKS_PER_ROW > 1) ? $clog2(BLOCKS_PER_ROW) : 1;
  localparam int RRW            = (BAND_ROWS > 1) ? $clog2(BAND_ROWS) : 1;
  localparam int RBW            = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int WBW            = $clog2(NUM_BANDS + 1);

  // Data is passed through untouched, so the fixed-point format only needs to be sane.
  if (FRAC_WIDTH > WIDTH) begin : g_frac_out_of_range
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [1:0]      full;
  logic [1:0]      full_set;
  logic [1:0]      full_clr;
  logic            wr_bank;
  logic            rd_bank;
  logic [CW-1:0]   wr_col;
  logic [WBW-1:0]  wr_band;
  logic [RRW-1:0]  rd_row;
  logic [RBW-1:0]  rd_band;
  logic            in_fire;
  logic            out_fire;
  logic            last_beat;
  logic            last_row;

  // Each bank entry keeps a whole beat; a row is gathered across all block columns on read.
  logic [IN_W-1:0] mem [2][BLOCKS_PER_ROW];

  assign in_ready    = (state == RUN) && en && !full[wr_bank] && (wr_band < WBW'(NUM_BANDS));
  assign out_valid   = (state == RUN) && full[rd_bank];
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign last_beat   = (wr_col == CW'(BLOCKS_PER_ROW - 1));
  assign last_row    = (rd_row == RRW'(BAND_ROWS - 1));
  assign out_row_idx = RW'(rd_band) * RW'(BAND_ROWS) + RW'(rd_row);

  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (in_fire && last_beat) full_set = 2'b01 << wr_bank;
    if (out_fire && last_row) full_clr = 2'b01 << rd_bank;
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_bank][wr_col] <= in_data;
  end

  // Row rd_row of block column c is a contiguous SLICE_W run inside the stored beat.
  for (genvar c = 0; c < BLOCKS_PER_ROW; c++) begin : g_col
    assign out_data[WIDTH*COL-1-c*SLICE_W -: SLICE_W] =
      SLICE_W'(mem[rd_bank][c] >> ((BAND_ROWS - 1 - int'(rd_row)) * SLICE_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      full        <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_col      <= '0;
      wr_band     <= '0;
      rd_row      <= '0;
      rd_band     <= '0;
      band_done   <= 1'b0;
      buffer_done <= 1'b0;
    end else begin
      band_done   <= 1'b0;
      buffer_done <= 1'b0;
      case (state)
        IDLE: if (en) state <= RUN;
        RUN: begin
          full <= (full | full_set) & ~full_clr;
          if (in_fire) begin
            if (last_beat) begin
              wr_col  <= '0;
              wr_bank <= ~wr_bank;
              wr_band <= wr_band + WBW'(1);
            end else begin
              wr_col <= wr_col + CW'(1);
            end
          end
          if (out_fire) begin
            if (last_row) begin
              rd_row    <= '0;
              rd_bank   <= ~rd_bank;
              band_done <= 1'b1;
              // Final row: clear everything now so the next matrix starts clean after DONE.
              if (rd_band == RBW'(NUM_BANDS - 1)) begin
                rd_band     <= '0;
                wr_band     <= '0;
                wr_bank     <= 1'b0;
                rd_bank     <= 1'b0;
                state       <= DONE;
                buffer_done <= 1'b1;
              end else begin
                rd_band <= rd_band + RBW'(1);
              end
            end else begin
              rd_row <= rd_row + RRW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
